// File: rtl/toggle_pulse_rx_ack.sv
// toggle_pulse_rx_ack: receive end of the toggle-pulse CDC link (receive clock domain only)
//   clk       receive-domain clock
//   rst_n     asynchronous active-low reset
//   enable    sender toggle line (async); one level change = one word
//   data_in   sender data, quasi-static around the toggle
//   data_out  held word presented downstream
//   valid     data_out holds an unconsumed word
//   ready     downstream accepts; transfer on valid && ready
//   ack       acknowledge toggle back to the sender
//   overrun   sticky: word arrived while full and not draining
//   rx_cnt    words accepted into the holding register (wraps)
// Optional macro TOGGLE_PULSE_ACK_EN: ack flips on every handshake; otherwise ack is tied 0.
module toggle_pulse_rx_ack #(
  parameter int DW          = 9,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DW-1:0]    data_in,
  output logic [DW-1:0]    data_out,
  output logic             valid,
  input  logic             ready,
  output logic             ack,
  output logic             overrun,
  output logic [CNT_W-1:0] rx_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic e_d, pulse;
  // pulse is registered so the word lands SYNC_STAGES+1 edges after enable is first sampled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= '0;
      e_d   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], enable};
      e_d   <= sync[SYNC_STAGES-1];
      pulse <= sync[SYNC_STAGES-1] ^ e_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= EMPTY;
      valid    <= 1'b0;
      data_out <= '0;
      rx_cnt   <= '0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        EMPTY:
          if (pulse) begin
            data_out <= data_in;
            rx_cnt   <= rx_cnt + 1'b1;
            valid    <= 1'b1;
            state    <= FULL;
          end
        FULL:
          if (ready) begin
            if (pulse) begin
              data_out <= data_in;
              rx_cnt   <= rx_cnt + 1'b1;
            end else begin
              valid <= 1'b0;
              state <= EMPTY;
            end
          end else if (pulse) overrun <= 1'b1;
        default: begin
          valid <= 1'b0;
          state <= EMPTY;
        end
      endcase
    end
`ifdef TOGGLE_PULSE_ACK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ack <= 1'b0;
    else if (valid && ready) ack <= ~ack;
`else
  assign ack = 1'b0;
`endif
endmodule

// File: tb/tb_toggle_pulse_rx_ack.sv
// tb_toggle_pulse_rx_ack: scoreboard bench for toggle_pulse_rx_ack (directed words, negedge monitor)
module tb_toggle_pulse_rx_ack;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [8:0] data_in = '0;
  logic [8:0] data_out;
  logic       valid, ready = 1'b0, ack, overrun;
  logic [7:0] rx_cnt;
  logic [8:0] q[$];
  logic       exp_ack = 1'b0;
  int         total = 0, bad = 0;

  toggle_pulse_rx_ack dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in), .data_out(data_out),
    .valid(valid), .ready(ready), .ack(ack), .overrun(overrun), .rx_cnt(rx_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every handshake pops one expected word; ack tracks handshakes when enabled
  always @(negedge clk) begin
    if (!rst_n) exp_ack = 1'b0;
    else begin
      chk("ack", ack, exp_ack);
      if (valid && ready) begin
        if (q.size() == 0) chk("unexpected_word", data_out, 9'h1ff);
        else chk("data_out", data_out, q.pop_front());
`ifdef TOGGLE_PULSE_ACK_EN
        exp_ack = ~exp_ack;
`endif
      end
    end
  end

  task automatic send(input logic [8:0] w, input bit accept);
    @(posedge clk) #1;
    data_in = w;
    enable = ~enable;
    if (accept) q.push_back(w);
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    rst_n = 1'b0;
    enable = 1'b0;
    ready = 1'b0;
    q.delete();
    @(posedge clk) #1;
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cnt", rx_cnt, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 20) begin
      @(posedge clk) #1;
      n++;
    end
    if (!valid) chk(name, 0, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    ready = 1'b1;
    while ((q.size() != 0 || valid) && n < 50) begin
      @(posedge clk) #1;
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    #7;
    chk("t1_data_out", data_out, 0);
    chk("t1_valid", valid, 0);
    chk("t1_ack", ack, 0);
    chk("t1_overrun", overrun, 0);
    chk("t1_cnt", rx_cnt, 0);
    enable = 1'b0;
    #3 rst_n = 1'b1;
    // single word: valid appears after the 4th edge following the toggle drive
    ready = 1'b1;
    send(9'h005, 1);
    repeat (3) @(posedge clk);
    #1 chk("t2_early", valid, 0);
    @(posedge clk) #1;
    chk("t2_valid", valid, 1);
    chk("t2_data", data_out, 9'h005);
    chk("t2_cnt", rx_cnt, 1);
    @(posedge clk) #1;
    chk("t2_one_clk", valid, 0);
`ifdef TOGGLE_PULSE_ACK_EN
    chk("t2_ack", ack, 1);
`endif
    // backpressure
    ready = 1'b0;
    send(9'h00a, 1);
    wait_valid("t3_timeout");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1;
      chk("t3_hold_valid", valid, 1);
      chk("t3_hold_data", data_out, 9'h00a);
    end
    ready = 1'b1;
    @(posedge clk) #1;
    chk("t3_consumed", valid, 0);
    chk("t3_cnt", rx_cnt, 2);
    // overrun
    do_reset();
    send(9'h011, 1);
    repeat (5) @(posedge clk);
    send(9'h012, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_data", data_out, 9'h011);
    chk("t4_overrun", overrun, 1);
    chk("t4_cnt", rx_cnt, 1);
    drain("t4_drain");
    repeat (3) @(posedge clk);
    #1 chk("t4_one_transfer", valid, 0);
    // simultaneous handshake and pulse
    do_reset();
    send(9'h01f, 1);
    wait_valid("t5_timeout");
    send(9'h020, 1);
    repeat (3) @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk) #1;
    ready = 1'b0;
    chk("t5_valid", valid, 1);
    chk("t5_data", data_out, 9'h020);
    chk("t5_overrun", overrun, 0);
    chk("t5_cnt", rx_cnt, 2);
    drain("t5_drain");
    // wrap
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(9'(i), 1);
      repeat (4) @(posedge clk);
    end
    drain("t6_drain");
    #1;
    chk("t6_cnt_wrap", rx_cnt, 0);
    chk("t6_ack_end", ack, 0);
    chk("t6_overrun", overrun, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
